// File: rtl/input_cond_pkg.sv
// Shared constants for the input-conditioning blocks (debouncer and friends).
package input_cond_pkg;

  localparam int TICK_DIV_DEF     = 250000;
  localparam int STABLE_TICKS_DEF = 4;
  localparam int PRESS_CNT_W      = 8;

endpackage

// File: rtl/debounce_bit.sv
// One debounced input: two-flop synchroniser, tick-qualified stable counter,
// debounced level and registered rise/fall pulses.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);

  logic             s1_reg;
  logic             s2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             dout_reg;
  logic             dout_next;
  logic             rise_reg;
  logic             rise_next;
  logic             fall_reg;
  logic             fall_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      cnt_reg  <= '0;
      dout_reg <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      cnt_reg  <= cnt_next;
      dout_reg <= dout_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

  // A match on any cycle, tick or not, discards partial qualification.
  always_comb begin
    cnt_next  = cnt_reg;
    dout_next = dout_reg;
    rise_next = 1'b0;
    fall_next = 1'b0;
    if (s2_reg == dout_reg) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt_reg == CNT_W'(STABLE_TICKS - 1)) begin
        dout_next = s2_reg;
        cnt_next  = '0;
        rise_next = s2_reg;
        fall_next = ~s2_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign dout = dout_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/button_debouncer.sv
// WIDTH-bit switch/button conditioner: shared sample-tick prescaler, per-bit
// debouncers and a wrapping press counter for bit 0.
module button_debouncer
  import input_cond_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall,
  output logic [PRESS_CNT_W-1:0] press_cnt,
  output logic                   tick
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]       presc_reg;
  logic [PRE_W-1:0]       presc_next;
  logic [PRESS_CNT_W-1:0] press_cnt_reg;
  logic [PRESS_CNT_W-1:0] press_cnt_next;

  // tick is decoded from the counter so it is 1 exactly during the wrap cycle.
  assign tick = (presc_reg == PRE_W'(TICK_DIV - 1));

  always_comb begin
    presc_next     = presc_reg + 1'b1;
    press_cnt_next = press_cnt_reg;
    if (tick) begin
      presc_next = '0;
    end
    if (rise[0]) begin
      press_cnt_next = press_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg     <= '0;
      press_cnt_reg <= '0;
    end else begin
      presc_reg     <= presc_next;
      press_cnt_reg <= press_cnt_next;
    end
  end

  assign press_cnt = press_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .STABLE_TICKS(STABLE_TICKS)
      ) u_bit (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .din  (din[gi]),
        .dout (dout[gi]),
        .rise (rise[gi]),
        .fall (fall[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with TICK_DIV=4, STABLE_TICKS=3, WIDTH=8.
module tb_button_debouncer;

  localparam int WIDTH        = 8;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [7:0]       press_cnt;
  logic             tick;

  int n_checks = 0;
  int n_fail   = 0;

  int rise_cnt [WIDTH];
  int fall_cnt [WIDTH];
  int dbl_pulse = 0;
  int both_pulse = 0;
  logic [WIDTH-1:0] rise_prev;
  logic [WIDTH-1:0] fall_prev;

  int press_model = 0;
  int rise0_model = 0;
  int fall0_model = 0;

  button_debouncer #(
    .WIDTH(WIDTH),
    .TICK_DIV(TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .dout(dout),
    .rise(rise),
    .fall(fall),
    .press_cnt(press_cnt),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  initial begin
    for (int i = 0; i < WIDTH; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    rise_prev = '0;
    fall_prev = '0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rise[i] === 1'b1) rise_cnt[i]++;
      if (fall[i] === 1'b1) fall_cnt[i]++;
    end
    if (((rise & rise_prev) | (fall & fall_prev)) != '0) dbl_pulse++;
    if ((rise & fall) != '0) both_pulse++;
    rise_prev = rise;
    fall_prev = fall;
  end

  // Called right after a negedge; counts posedges until dout[idx] == val.
  task automatic wait_dout(input int idx, input logic val, input int max_e, output int edges);
    edges = 0;
    while (dout[idx] !== val && edges < max_e) begin
      @(negedge clk);
      edges++;
    end
    if (dout[idx] !== val) check("dout_timeout", {31'd0, dout[idx]}, {31'd0, val});
  endtask

  task automatic press_release_bit0();
    int e;
    din[0] = 1'b1;
    wait_dout(0, 1'b1, 20, e);
    press_model++;
    rise0_model++;
    din[0] = 1'b0;
    wait_dout(0, 1'b0, 20, e);
    fall0_model++;
  endtask

  initial begin
    int e;
    logic [7:0] tick_pat;
    logic b;

    rst = 1'b1;
    din = '0;
    repeat (3) @(negedge clk);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_pulses", {16'd0, rise, fall}, 32'd0);
    check("reset_press_tick", {23'd0, press_cnt, tick}, 32'd0);

    // Tick after release: presc 1,2,3 -> tick high after edge 3, acted on at edge 4.
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tick_pat[k] = tick;
    end
    check("tick_pattern", {24'd0, tick_pat}, 32'h44);

    // Clean press and release on bit 0.
    din[0] = 1'b1;
    wait_dout(0, 1'b1, 20, e);
    check("press_latency_in_11_14", {31'd0, (e >= 11 && e <= 14)}, 32'd1);
    check("rise0_on", {31'd0, rise[0]}, 32'd1);
    press_model++;
    rise0_model++;
    @(negedge clk);
    check("rise0_off", {31'd0, rise[0]}, 32'd0);
    check("press_cnt_1", {24'd0, press_cnt}, press_model);
    din[0] = 1'b0;
    wait_dout(0, 1'b0, 20, e);
    check("release_latency_in_11_14", {31'd0, (e >= 11 && e <= 14)}, 32'd1);
    check("fall0_on", {31'd0, fall[0]}, 32'd1);
    fall0_model++;
    @(negedge clk);
    check("fall0_off_press_same", {23'd0, fall[0], press_cnt}, {23'd0, 1'b0, 8'(press_model)});

    // Bounce: 3-cycle segments never collect 3 ticks.
    b = 1'b0;
    for (int s = 0; s < 10; s++) begin
      b = ~b;
      din[0] = b;
      repeat (3) @(negedge clk);
    end
    check("bounce_no_change", {30'd0, dout[0], 1'b0} | rise_cnt[0], rise0_model);
    din[0] = 1'b1;
    wait_dout(0, 1'b1, 20, e);
    press_model++;
    rise0_model++;
    @(negedge clk);
    check("bounce_single_rise", rise_cnt[0], rise0_model);
    check("bounce_press_cnt", {24'd0, press_cnt}, press_model);
    din[0] = 1'b0;
    wait_dout(0, 1'b0, 20, e);
    fall0_model++;

    // Short pulse on bit 3: 8 cycles < (3-1)*4+1, always rejected.
    din[3] = 1'b1;
    repeat (8) @(negedge clk);
    din[3] = 1'b0;
    repeat (20) @(negedge clk);
    check("short_dout3", {31'd0, dout[3]}, 32'd0);
    check("short_pulses3", rise_cnt[3] + fall_cnt[3], 32'd0);

    // Multi-bit simultaneous change.
    din = 8'hA5;
    e = 0;
    while (dout == 8'h00 && e < 20) begin
      @(negedge clk);
      e++;
    end
    check("multi_dout", {24'd0, dout}, 32'hA5);
    check("multi_rise", {24'd0, rise}, 32'hA5);
    press_model++;
    rise0_model++;
    @(negedge clk);
    check("multi_rise_off", {24'd0, rise}, 32'h00);

    // Reset mid-run with outputs active: async clear before the next edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dout", {24'd0, dout}, 32'd0);
    check("async_rst_press_tick", {23'd0, press_cnt, tick}, 32'd0);
    press_model = 0;
    din = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Wrap: 255 then 0.
    for (int p = 0; p < 255; p++) press_release_bit0();
    check("wrap_255", {24'd0, press_cnt}, 32'd255);
    press_release_bit0();
    check("wrap_0", {24'd0, press_cnt}, press_model % 256);

    // 257th press interrupted by reset mid-qualification.
    din[0] = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("qual_rst_outputs", {15'd0, dout[0], rise, press_cnt}, 32'd0);
    din[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("qual_rst_no_rise", rise_cnt[0], rise0_model);
    check("fall0_total", fall_cnt[0], fall0_model);
    check("pulse_single_cycle", dbl_pulse, 32'd0);
    check("rise_fall_exclusive", both_pulse, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
